// File: rtl/lru_tracker_if.sv
// Request/query bundle for lru_tracker: touch and invalidate strobes plus the
// set-indexed lru/mru read port and the error pulse.
interface lru_tracker_if #(
  parameter int WAYS = 4,
  parameter int SETS = 4
);
  localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1;
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

  // Requests are single-cycle strobes with no ready: whatever touch_we/inval_we
  // hold at a falling clock edge is taken (or rejected with err) on that edge.
  logic             touch_we;
  logic [SET_W-1:0] touch_set;
  logic [WAY_W-1:0] touch_way;
  logic             inval_we;
  logic [SET_W-1:0] inval_set;
  logic [WAY_W-1:0] inval_way;
  logic [SET_W-1:0] rd_set;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] mru_way;
  logic             err;

  modport master (
    output touch_we, touch_set, touch_way, inval_we, inval_set, inval_way, rd_set,
    input  lru_way, mru_way, err
  );

  modport slave (
    input  touch_we, touch_set, touch_way, inval_we, inval_set, inval_way, rd_set,
    output lru_way, mru_way, err
  );
endinterface

// File: rtl/lru_tracker.sv
// Per-set true-LRU ordering: each set keeps a permutation of way indices,
// slot 0 = LRU, slot WAYS-1 = MRU. State updates on the falling clock edge.
module lru_tracker #(
  parameter int WAYS = 4,
  parameter int SETS = 4
) (
  input  logic         CLK,
  input  logic         RST_N,
  lru_tracker_if.slave bus
);
  localparam int WAY_W = (WAYS > 2) ? $clog2(WAYS) : 1;
  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

  typedef logic [WAY_W-1:0] way_t;

  way_t slot_q [SETS][WAYS];
  way_t slot_d [SETS][WAYS];
  logic err_q;

  logic touch_ok;
  logic inval_ok;
  logic inval_apply;
  logic err_d;
  logic seen;
  way_t lru_rd;
  way_t mru_rd;

  always_comb begin
    touch_ok    = bus.touch_we && (int'(bus.touch_way) < WAYS) && (int'(bus.touch_set) < SETS);
    inval_ok    = bus.inval_we && (int'(bus.inval_way) < WAYS) && (int'(bus.inval_set) < SETS);
    // A touch wins over an invalidate aimed at the same set; that is not an error.
    inval_apply = inval_ok && !(touch_ok && (bus.touch_set == bus.inval_set));
    err_d       = (bus.touch_we && !touch_ok) || (bus.inval_we && !inval_ok);
  end

  always_comb begin
    slot_d = slot_q;
    seen   = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      if (touch_ok && (bus.touch_set == SET_W'(s))) begin
        seen = 1'b0;
        for (int i = 0; i < WAYS - 1; i++) begin
          seen = seen | (slot_q[s][i] == bus.touch_way);
          if (seen) slot_d[s][i] = slot_q[s][i+1];
        end
        slot_d[s][WAYS-1] = bus.touch_way;
      end
      // Mirror image of touch: everything below the hit shifts up one slot.
      if (inval_apply && (bus.inval_set == SET_W'(s))) begin
        seen = 1'b0;
        for (int i = WAYS - 1; i > 0; i--) begin
          seen = seen | (slot_q[s][i] == bus.inval_way);
          if (seen) slot_d[s][i] = slot_q[s][i-1];
        end
        slot_d[s][0] = bus.inval_way;
      end
    end
  end

  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < SETS; s++) begin
        for (int i = 0; i < WAYS; i++) begin
          slot_q[s][i] <= way_t'(i);
        end
      end
      err_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    lru_rd = '0;
    mru_rd = '0;
    for (int s = 0; s < SETS; s++) begin
      if (bus.rd_set == SET_W'(s)) begin
        lru_rd = slot_q[s][0];
        mru_rd = slot_q[s][WAYS-1];
      end
    end
  end

  assign bus.lru_way = lru_rd;
  assign bus.mru_way = mru_rd;
  assign bus.err     = err_q;
endmodule

// File: doc/lru_tracker.md
LRU_TRACKER -- requirements
Module: lru_tracker

Interface
REQ-001 SHALL have parameter WAYS, default 4, meaning associativity tracked per set (legal range 2..16, any integer).
REQ-002 SHALL have parameter SETS, default 4, meaning number of independent LRU orderings (legal range 1..64).
REQ-003 SHALL have derived localparams WAY_W = max(1, clog2(WAYS)) and SET_W = max(1, clog2(SETS)).
REQ-004 SHALL have port CLK  input  1  single clock; all state updates occur on the falling edge.
REQ-005 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port touch_we  input  1  request to mark touch_way most-recently-used in touch_set.
REQ-007 SHALL have port touch_set  input  SET_W  set index for touch.
REQ-008 SHALL have port touch_way  input  WAY_W  way index for touch.
REQ-009 SHALL have port inval_we  input  1  request to demote inval_way to least-recently-used in inval_set.
REQ-010 SHALL have port inval_set  input  SET_W  set index for invalidate.
REQ-011 SHALL have port inval_way  input  WAY_W  way index for invalidate.
REQ-012 SHALL have port rd_set  input  SET_W  set queried by the lru/mru outputs.
REQ-013 SHALL have port lru_way  output  WAY_W  least-recently-used way of rd_set.
REQ-014 SHALL have port mru_way  output  WAY_W  most-recently-used way of rd_set.
REQ-015 SHALL have port err  output  1  one-cycle registered pulse on an illegal request.

Function
REQ-016 Each set SHALL hold an ordered list slot[0..WAYS-1] of way indices; slot[0] = LRU, slot[WAYS-1] = MRU; the list is always a permutation of 0..WAYS-1.
REQ-017 lru_way SHALL equal slot[0] of rd_set and mru_way SHALL equal slot[WAYS-1] of rd_set, combinationally (zero latency from rd_set and from state).
REQ-018 Touch: at position p where slot[p] == touch_way, slots p..WAYS-2 SHALL take the value of slot p+1, slot[WAYS-1] SHALL take touch_way, and slots below p SHALL be unchanged.
REQ-019 Touch of a way already at MRU SHALL leave the list unchanged.
REQ-020 Invalidate: at position p where slot[p] == inval_way, slots 1..p SHALL take the value of slot p-1, slot[0] SHALL take inval_way, and slots above p SHALL be unchanged.
REQ-021 Invalidate of a way already at LRU SHALL leave the list unchanged.
REQ-022 Update latency SHALL be one falling edge; lru_way/mru_way reflect the update immediately after that edge.
REQ-023 Touch and invalidate on different sets in the same cycle SHALL both be applied.
REQ-024 Touch and invalidate on the same set in the same cycle SHALL apply only the touch; err SHALL NOT assert for this case.
REQ-025 A request with way index >= WAYS (possible only when WAYS is not a power of two) or set index >= SETS SHALL be ignored with no state change and SHALL set err high for the following cycle.
REQ-026 err SHALL be registered on the falling edge and low in any cycle with no illegal request.
REQ-027 Sets not addressed by a legal request SHALL hold their state.

Reset
REQ-028 Assertion of RST_N low SHALL immediately, independent of CLK, set every set to slot[i] = i and clear err.
REQ-029 After reset with rd_set = 0, lru_way SHALL read 0 and mru_way SHALL read WAYS-1.
REQ-030 Requests presented while RST_N is low SHALL be discarded; the first update occurs on the first falling edge after RST_N deasserts.
REQ-031 Reset asserted between request presentation and the falling edge SHALL leave state at the reset order.

Verification
REQ-032 WAYS=4, SETS=2: reset, then touch set0 ways 0,1,2 on successive cycles -> set0 lru_way=3, mru_way=2; set1 stays lru 0 / mru 3.
REQ-033 From reset order, invalidate set0 way 3 -> set0 order 3,0,1,2; lru_way=3, mru_way=2.
REQ-034 Same cycle touch set1 way 0 and invalidate set1 way 2 -> only touch applied: set1 order 1,2,3,0; err=0.
REQ-035 Same cycle touch set0 way 1 and invalidate set1 way 3 -> set0 order 0,2,3,1 and set1 order 3,0,1,2.
REQ-036 WAYS=3: touch_way=3 -> no state change, err=1 for exactly one cycle; then touch way 0 -> order 1,2,0, err=0.
REQ-037 Random touch/invalidate stream of 10000 cycles with RST_N pulsed mid-stream -> every set is a permutation at every cycle, matches a reference list model, and returns to identity order on reset.
